// File: rtl/axis_msg_packer_if.sv
// AXI-Stream bundle shared by the narrow input and wide output sides of the packer.
// Widths are set per instance; the packer owns tready on its slave side.
interface axis_msg_packer_if #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, output tkeep, output tuser, output tvalid, output tlast,
                    input  tready);
    modport slave  (input  tdata, input  tkeep, input  tuser, input  tvalid, input  tlast,
                    output tready);
endinterface

// File: rtl/axis_msg_packer.sv
// Packs narrow AXI-Stream beats into wide words with byte-accurate tkeep.
// The output register doubles as the accumulator; tlast closes a word early.
module axis_msg_packer #(
    parameter int unsigned S_AXIS_DATA_WIDTH = 64,
    parameter int unsigned M_AXIS_DATA_WIDTH = 512,
    parameter int unsigned AXIS_TUSER_WIDTH  = 128
) (
    input  logic                axis_aclk,
    input  logic                axis_resetn,
    axis_msg_packer_if.slave    s_axis,
    axis_msg_packer_if.master   m_axis
);
    localparam int unsigned RATIO  = M_AXIS_DATA_WIDTH / S_AXIS_DATA_WIDTH;
    localparam int unsigned SK     = S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned MK     = M_AXIS_DATA_WIDTH / 8;
    localparam int unsigned SLOT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [SLOT_W-1:0]            r_slot;
    logic [M_AXIS_DATA_WIDTH-1:0] r_data;
    logic [MK-1:0]                r_keep;
    logic [AXIS_TUSER_WIDTH-1:0]  r_user;
    logic                         r_valid;
    logic                         r_last;

    logic                         w_s_ready;
    logic                         w_accept;
    logic                         w_close;
    logic [M_AXIS_DATA_WIDTH-1:0] w_data_next;
    logic [MK-1:0]                w_keep_next;

    assign w_s_ready = axis_resetn & (~r_valid | m_axis.tready);
    assign w_accept  = s_axis.tvalid & w_s_ready;
    assign w_close   = w_accept & ((r_slot == SLOT_W'(RATIO - 1)) | s_axis.tlast);

    // Lane 0 starts a fresh word, so the rest of the register is cleared with it
    always_comb begin
        w_data_next = (r_slot == '0) ? '0 : r_data;
        w_keep_next = (r_slot == '0) ? '0 : r_keep;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (r_slot == SLOT_W'(k)) begin
                w_data_next[k*S_AXIS_DATA_WIDTH +: S_AXIS_DATA_WIDTH] = s_axis.tdata;
                w_keep_next[k*SK +: SK]                               = s_axis.tkeep;
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            r_slot  <= '0;
            r_data  <= '0;
            r_keep  <= '0;
            r_user  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (r_valid && m_axis.tready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
            if (w_accept) begin
                r_data <= w_data_next;
                r_keep <= w_keep_next;
                if (r_slot == '0) r_user <= s_axis.tuser;
                if (w_close) begin
                    r_valid <= 1'b1;
                    r_last  <= s_axis.tlast;
                    r_slot  <= '0;
                end else begin
                    r_slot  <= r_slot + 1'b1;
                end
            end
        end
    end

    assign s_axis.tready = w_s_ready;
    assign m_axis.tdata  = r_data;
    assign m_axis.tkeep  = r_keep;
    assign m_axis.tuser  = r_user;
    assign m_axis.tvalid = r_valid;
    assign m_axis.tlast  = r_last;
endmodule

// File: tb/tb_axis_msg_packer.sv
// Directed bench for axis_msg_packer: 64-bit beats packed into 512-bit words.
`timescale 1ns/1ps
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_axis_msg_packer;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   stalls = 0;
    int   cyc = 0;

    logic [511:0] q_data[$];
    logic [63:0]  q_keep[$];
    logic [127:0] q_user[$];
    logic         q_last[$];
    int           q_cyc[$];

    logic [511:0] exp_d;

    axis_msg_packer_if #(.DATA_WIDTH(64),  .TUSER_WIDTH(128)) s_if ();
    axis_msg_packer_if #(.DATA_WIDTH(512), .TUSER_WIDTH(128)) m_if ();

    axis_msg_packer #(
        .S_AXIS_DATA_WIDTH(64),
        .M_AXIS_DATA_WIDTH(512),
        .AXIS_TUSER_WIDTH(128)
    ) dut (
        .axis_aclk   (clk),
        .axis_resetn (rstn),
        .s_axis      (s_if),
        .m_axis      (m_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rstn && m_if.tvalid && m_if.tready) begin
            q_data.push_back(m_if.tdata);
            q_keep.push_back(m_if.tkeep);
            q_user.push_back(m_if.tuser);
            q_last.push_back(m_if.tlast);
            q_cyc.push_back(cyc);
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                             input logic [127:0] u, input logic l);
        int w;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        w = 0;
        while (!s_if.tready && w < 100) begin
            @(posedge clk); #1;
            w++;
            stalls++;
        end
        if (!s_if.tready) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=%0d expected=ready", w);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_words(input int n);
        int w;
        w = 0;
        while (q_data.size() < n && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        `CHK("word_count", q_data.size(), n)
    endtask

    task automatic clear_q();
        q_data.delete(); q_keep.delete(); q_user.delete(); q_last.delete(); q_cyc.delete();
    endtask

    initial begin
        s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
        m_if.tready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        `CHK("rst_tvalid", m_if.tvalid, 1'b0)
        `CHK("rst_tlast",  m_if.tlast,  1'b0)
        `CHK("rst_tdata",  m_if.tdata,  512'h0)
        `CHK("rst_tkeep",  m_if.tkeep,  64'h0)
        `CHK("rst_tuser",  m_if.tuser,  128'h0)
        `CHK("rst_sready", s_if.tready, 1'b0)
        rstn = 1'b1;
        @(posedge clk); #1;
        `CHK("post_rst_sready", s_if.tready, 1'b1)

        // 1: full 8-beat packet, latency one cycle
        clear_q();
        exp_d = '0;
        for (int k = 1; k <= 8; k++) begin
            exp_d[(k-1)*64 +: 64] = 64'(k) * 64'h1111111111111111;
            send_beat(64'(k) * 64'h1111111111111111, 8'hFF, 128'h0, k == 8);
            if (k == 7) `CHK("t1_no_early_valid", m_if.tvalid, 1'b0)
        end
        `CHK("t1_latency_valid", m_if.tvalid, 1'b1)
        idle(1);
        wait_words(1);
        `CHK("t1_data", q_data[0], exp_d)
        `CHK("t1_keep", q_keep[0], 64'hFFFF_FFFF_FFFF_FFFF)
        `CHK("t1_last", q_last[0], 1'b1)
        idle(2);

        // 2: short packet with partial keep on the last beat
        clear_q();
        send_beat(64'h0102030405060708, 8'hFF, 128'h0, 1'b0);
        send_beat(64'h1112131415161718, 8'hFF, 128'h0, 1'b0);
        send_beat(64'h8877665544332211, 8'h0F, 128'h0, 1'b1);
        idle(1);
        wait_words(1);
        `CHK("t2_data", q_data[0], {320'h0, 64'h8877665544332211, 64'h1112131415161718, 64'h0102030405060708})
        `CHK("t2_keep", q_keep[0], 64'h0000_0000_000F_FFFF)
        `CHK("t2_last", q_last[0], 1'b1)
        idle(2);

        // 3: 16 beats, tuser = beat index
        clear_q();
        for (int k = 0; k < 16; k++)
            send_beat(64'h100 + 64'(k), 8'hFF, 128'(k), k == 15);
        idle(1);
        wait_words(2);
        `CHK("t3_last0", q_last[0], 1'b0)
        `CHK("t3_last1", q_last[1], 1'b1)
        `CHK("t3_user0", q_user[0], 128'd0)
        `CHK("t3_user1", q_user[1], 128'd8)
        `CHK("t3_w1_lane0", q_data[1][63:0], 64'h108)
        `CHK("t3_w0_lane7", q_data[0][511:448], 64'h107)
        idle(2);

        // 4: back-pressure holds the word; blocked beat then closes on the accept edge
        clear_q();
        m_if.tready = 1'b0;
        exp_d = '0;
        for (int k = 0; k < 8; k++) begin
            exp_d[k*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(k);
            send_beat(64'hC0DE_0000_0000_0000 | 64'(k), 8'hFF, 128'h4, k == 7);
        end
        s_if.tdata = 64'hB0B0_B0B0_B0B0_B0B0; s_if.tkeep = 8'hFF;
        s_if.tuser = 128'h5; s_if.tlast = 1'b1; s_if.tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            `CHK("t4_hold_valid",  m_if.tvalid, 1'b1)
            `CHK("t4_hold_data",   m_if.tdata,  exp_d)
            `CHK("t4_hold_sready", s_if.tready, 1'b0)
            @(posedge clk); #1;
        end
        m_if.tready = 1'b1;
        @(posedge clk); #1;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
        `CHK("t4_new_word_valid", m_if.tvalid, 1'b1)
        wait_words(2);
        `CHK("t4_w0_data", q_data[0], exp_d)
        `CHK("t4_w0_user", q_user[0], 128'h4)
        `CHK("t4_w1_data", q_data[1], {448'h0, 64'hB0B0_B0B0_B0B0_B0B0})
        `CHK("t4_w1_keep", q_keep[1], 64'hFF)
        `CHK("t4_w1_user", q_user[1], 128'h5)
        `CHK("t4_w1_last", q_last[1], 1'b1)
        idle(2);

        // 5: continuous 24-beat packet, no stalls, words 8 cycles apart
        clear_q();
        stalls = 0;
        for (int k = 0; k < 24; k++)
            send_beat(64'h5000 + 64'(k), 8'hFF, 128'h0, k == 23);
        idle(1);
        wait_words(3);
        `CHK("t5_stalls", stalls, 0)
        `CHK("t5_gap01", q_cyc[1] - q_cyc[0], 8)
        `CHK("t5_gap12", q_cyc[2] - q_cyc[1], 8)
        `CHK("t5_last", {q_last[0], q_last[1], q_last[2]}, 3'b001)
        `CHK("t5_w2_lane0", q_data[2][63:0], 64'h5010)
        idle(2);

        // 6: reset discards a partial word
        clear_q();
        for (int k = 0; k < 4; k++)
            send_beat(64'hDEAD_0000_0000_0000 | 64'(k), 8'hFF, 128'h9, 1'b0);
        idle(0);
        rstn = 1'b0;
        #1;
        `CHK("t6_rst_sready", s_if.tready, 1'b0)
        @(posedge clk); #1;
        @(posedge clk); #1;
        `CHK("t6_rst_valid", m_if.tvalid, 1'b0)
        `CHK("t6_rst_data",  m_if.tdata,  512'h0)
        rstn = 1'b1;
        @(posedge clk); #1;
        send_beat(64'h1234_5678_9ABC_DEF0, 8'hFF, 128'h0, 1'b1);
        idle(1);
        wait_words(1);
        `CHK("t6_data", q_data[0], {448'h0, 64'h1234_5678_9ABC_DEF0})
        `CHK("t6_keep", q_keep[0], 64'hFF)
        `CHK("t6_last", q_last[0], 1'b1)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
